// File: rtl/trng_pool.sv
// trng_pool: ring-oscillator entropy pool with warmup, von Neumann debiasing and a repetition health test
// Ports: clk/reset (asynchronous, active-high); enable run request; test_mode/test_bit raw-bit injection;
// clear_fail clears a latched failure; out_data/out_valid/out_ready output word handshake;
// health_fail sticky failure flag; state IDLE=0 WARMUP=1 RUN=2 FAIL=3.
module trng_pool #(
    parameter int NUM_SRC   = 4,
    parameter int RING_LEN  = 3,
    parameter int OUT_W     = 8,
    parameter int REP_LIMIT = 16,
    parameter int WARMUP    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             test_mode,
    input  logic             test_bit,
    input  logic             clear_fail,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             health_fail,
    output logic [1:0]       state
);
    localparam int WW = $clog2(WARMUP + 1);
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam int CW = $clog2(OUT_W + 1);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WARM = 2'd1, S_RUN = 2'd2, S_FAIL = 2'd3} state_t;
    state_t state_q, state_d;
    logic [NUM_SRC-1:0][RING_LEN-1:0] ring_q;
    logic [WW-1:0] warm_q, warm_d;
    logic [RW-1:0] rep_q, rep_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] col_q, col_d, data_q, data_d;
    logic raw_q, last_q, last_d, phase_q, phase_d, pair_q, pair_d;
    logic valid_q, valid_d, fail_q, fail_d;
    logic src_bit, run, full, xfer, take;
    always_comb begin
        src_bit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) src_bit ^= ring_q[i][0];
    end
    assign run  = state_q == S_RUN && enable;
    assign full = cnt_q == CW'(OUT_W);
    assign xfer = run && full && (!valid_q || out_ready);
    // a full collector blocked by a held output word freezes raw consumption
    assign take = run && (!full || xfer);
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        rep_d   = rep_q;
        last_d  = last_q;
        phase_d = phase_q;
        pair_d  = pair_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = (valid_q && out_ready) ? 1'b0 : valid_q;
        fail_d  = fail_q;
        if (xfer) begin
            data_d  = col_q;
            valid_d = 1'b1;
            cnt_d   = '0;
        end
        if (take) begin
            // rep_q == 0 marks the first raw bit seen since entering RUN
            rep_d   = (rep_q != '0 && raw_q == last_q) ? rep_q + 1'b1 : RW'(1);
            last_d  = raw_q;
            phase_d = ~phase_q;
            pair_d  = raw_q;
            if (phase_q && pair_q != raw_q) begin
                col_d = {col_q[OUT_W-2:0], pair_q};
                cnt_d = cnt_d + 1'b1;
            end
        end
        case (state_q)
            S_IDLE: state_d = enable ? S_WARM : S_IDLE;
            S_WARM: begin
                warm_d  = warm_q + 1'b1;
                state_d = !enable ? S_IDLE : (warm_q == WW'(WARMUP - 1)) ? S_RUN : S_WARM;
            end
            S_RUN: begin
                if (!enable) state_d = S_IDLE;
                else if (take && rep_d == RW'(REP_LIMIT)) begin
                    state_d = S_FAIL;
                    fail_d  = 1'b1;
                    valid_d = 1'b0;
                end
            end
            S_FAIL: begin
                if (clear_fail) begin
                    fail_d  = 1'b0;
                    state_d = enable ? S_WARM : S_IDLE;
                end
            end
        endcase
        // every state change restarts collection; a pending output word survives unless entering FAIL
        if (state_d != state_q) begin
            warm_d  = '0;
            rep_d   = '0;
            phase_d = 1'b0;
            cnt_d   = '0;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) ring_q[i] <= RING_LEN'(1) << (i % RING_LEN);
            state_q <= S_IDLE;
            raw_q   <= 1'b0;
            warm_q  <= '0;
            rep_q   <= '0;
            last_q  <= 1'b0;
            phase_q <= 1'b0;
            pair_q  <= 1'b0;
            col_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++)
                ring_q[i] <= {~ring_q[i][RING_LEN-2], ring_q[i][RING_LEN-3:0], ring_q[i][RING_LEN-1]};
            state_q <= state_d;
            raw_q   <= test_mode ? test_bit : src_bit;
            warm_q  <= warm_d;
            rep_q   <= rep_d;
            last_q  <= last_d;
            phase_q <= phase_d;
            pair_q  <= pair_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fail_q  <= fail_d;
        end
    end
    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign health_fail = fail_q;
    assign state       = state_q;
endmodule

// File: doc/trng_pool.md
TRNG_POOL -- requirements
Module: trng_pool

Interface
REQ-001 SHALL provide parameter NUM_SRC, default 4: number of ring-oscillator sources, 1..16.
REQ-002 SHALL provide parameter RING_LEN, default 3: stages per ring, odd, at least 3.
REQ-003 SHALL provide parameter OUT_W, default 8: output word width, 2..64.
REQ-004 SHALL provide parameter REP_LIMIT, default 16: consecutive identical raw bits that trigger health failure, at least 2.
REQ-005 SHALL provide parameter WARMUP, default 32: raw bits discarded after start or restart, at least 1.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port enable, input, 1: run request.
REQ-009 SHALL have port test_mode, input, 1: replaces the combined source bit with test_bit.
REQ-010 SHALL have port test_bit, input, 1: injected raw bit.
REQ-011 SHALL have port clear_fail, input, 1: single-cycle pulse that clears a health failure.
REQ-012 SHALL have port out_data, output, OUT_W: random word.
REQ-013 SHALL have port out_valid, output, 1: out_data valid.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts.
REQ-015 SHALL have port health_fail, output, 1: sticky failure flag.
REQ-016 SHALL have port state, output, 2: IDLE=0, WARMUP=1, RUN=2, FAIL=3.

Function
REQ-017 Each source i SHALL be a RING_LEN-stage shift ring with stage0<=stage_last, stage_k<=stage_k-1, stage_last<=~stage_last-1, reset to one-hot at bit (i mod RING_LEN).
REQ-018 The raw bit SHALL be registered once per clk: XOR of every source's stage0, or test_bit when test_mode=1. The stage consumes the registered value on the following edge.
REQ-019 State IDLE -> WARMUP when enable=1; any state except FAIL -> IDLE when enable=0, discarding collector, pair and counters but keeping a pending output word.
REQ-020 WARMUP SHALL discard exactly WARMUP raw bits, then go to RUN with the pair phase at "first".
REQ-021 RUN SHALL apply von Neumann debiasing on non-overlapping raw pairs: 10->1, 01->0, 00 and 11 discarded.
REQ-022 Debiased bits SHALL shift into the collector LSB-first-in, so the first bit ends in the MSB.
REQ-023 When OUT_W debiased bits are collected and the output register is empty or handshaking that cycle, the word SHALL transfer; out_valid asserts on the next cycle.
REQ-024 If the collector is full and the output is still held, raw-bit consumption SHALL stall, and pair phase and health counter SHALL freeze.
REQ-025 out_data SHALL stay stable while out_valid=1 and out_ready=0; the word retires on out_valid&&out_ready.
REQ-026 In RUN, a counter SHALL track consecutive identical raw bits and reset to 1 on a change; reaching REP_LIMIT SHALL enter FAIL.
REQ-027 On entering FAIL: health_fail=1, out_valid=0, pending word and collector discarded; out_valid stays 0 in FAIL.
REQ-028 In FAIL, clear_fail=1 SHALL clear health_fail and go to WARMUP if enable=1, otherwise IDLE; enable is ignored until then.
REQ-029 Simultaneous failure detection and output handshake: FAIL takes priority and the handshaked word counts as delivered.

Reset
REQ-030 On reset, every ring SHALL load its one-hot seed; out_data=0, out_valid=0, health_fail=0, state=IDLE; collector, pair phase and counters SHALL clear.
REQ-031 Reset mid-operation SHALL abort any word in progress or pending, with no partial word emitted after release.

Verification
- Reset with enable=1: all outputs 0 and state=0 during reset; state=1 in the first cycle after release.
- test_mode=1, default params, after warmup feed pairs 10,01 x4: exactly one word, out_data=8'hAA, out_ready=1.
- Feed 00,11,10 repeated 8 times: out_data=8'hFF; 16 discarded pairs produce no extra bits.
- out_ready=0 while feeding 16 valid bits: first word held stable; second word in collector; further input ignored; on out_ready=1 the words deliver in order.
- test_bit=1 held for 16 raw bits in RUN: health_fail=1, state=3, out_valid=0; clear_fail pulse -> state=1, then 32 warmup bits before data.
- test_mode=0, NUM_SRC=4: 10,000 words with no health failure; reset mid-word -> out_valid=0 after release.
